// File: rtl/gsa_pkg.sv
// Shared types, defaults and the MISR step function for gate_sig_analyzer.
package gsa_pkg;

  typedef logic [1:0] gsa_state_t;

  localparam gsa_state_t StIdle = 2'd0;
  localparam gsa_state_t StRun  = 2'd1;
  localparam gsa_state_t StDone = 2'd2;

  localparam logic [15:0] DefaultPoly = 16'h1021;
  localparam logic [15:0] DefaultSeed = 16'h0000;

  // Width-generic MISR step; callers zero-extend to 64 bits and keep the low w bits.
  function automatic logic [63:0] misr_next(input logic [63:0] s, input logic [63:0] r,
                                            input logic [63:0] poly, input int unsigned w);
    logic [63:0] mask;
    logic [63:0] res;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    res  = (s << 1) ^ r;
    if (s[6'(w - 1)]) res = res ^ poly;
    return res & mask;
  endfunction

endpackage

// File: rtl/gate_sig_analyzer_if.sv
// Sweep control, response and result signals of gate_sig_analyzer.
interface gate_sig_analyzer_if #(
  parameter int unsigned IN_W  = 5,
  parameter int unsigned SIG_W = 16,
  parameter int unsigned CNT_W = 9
);
  logic             start;
  logic             resp_valid;
  logic [IN_W-1:0]  resp;
  logic [SIG_W-1:0] expected_sig;
  logic             busy;
  logic             done;
  logic             pass;
  logic [SIG_W-1:0] signature;
  logic [CNT_W:0]   vec_count;
  logic             timeout;

  modport master (
    output start, resp_valid, resp, expected_sig,
    input  busy, done, pass, signature, vec_count, timeout
  );

  modport slave (
    input  start, resp_valid, resp, expected_sig,
    output busy, done, pass, signature, vec_count, timeout
  );
endinterface

// File: rtl/gsa_misr.sv
// Signature register: loads SEED on load_seed, folds resp in on shift_en.
module gsa_misr
  import gsa_pkg::*;
#(
  parameter int unsigned      IN_W  = 5,
  parameter int unsigned      SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefaultPoly),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DefaultSeed)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_seed,
  input  logic             shift_en,
  input  logic [IN_W-1:0]  resp,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_next
);

  logic [SIG_W-1:0] sig_q;
  logic [63:0]      nxt_full;
  logic             unused_nxt_hi;

  assign nxt_full      = misr_next(64'(sig_q), 64'(resp), 64'(POLY), SIG_W);
  assign sig_next      = nxt_full[SIG_W-1:0];
  assign unused_nxt_hi = ^nxt_full[63:SIG_W];
  assign sig           = sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= SEED;
    end else if (load_seed) begin
      sig_q <= SEED;
    end else if (shift_en) begin
      sig_q <= sig_next;
    end
  end

endmodule

// File: rtl/gate_sig_analyzer.sv
// Response compactor: folds 2^CNT_W samples into a MISR and compares with a golden value.
// Optional watchdog abort enabled by defining GSA_TIMEOUT_EN.
module gate_sig_analyzer
  import gsa_pkg::*;
#(
  parameter int unsigned      IN_W  = 5,
  parameter int unsigned      SIG_W = 16,
  parameter int unsigned      CNT_W = 9,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DefaultPoly),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DefaultSeed),
  parameter int unsigned      TO_W  = 8
) (
  input logic                clk,
  input logic                rst_n,
  gate_sig_analyzer_if.slave bus
);

  localparam logic [CNT_W:0] LastCnt = {1'b0, {CNT_W{1'b1}}};

  gsa_state_t       state_q, state_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic             pass_q, pass_d;
  logic             load_seed, shift_en;
  logic [SIG_W-1:0] sig, sig_next;

  gsa_misr #(
    .IN_W (IN_W),
    .SIG_W(SIG_W),
    .POLY (POLY),
    .SEED (SEED)
  ) u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_seed(load_seed),
    .shift_en (shift_en),
    .resp     (bus.resp),
    .sig      (sig),
    .sig_next (sig_next)
  );

`ifdef GSA_TIMEOUT_EN
  // Counter value on the edge before it reaches 2^TO_W-1; DONE is entered on that edge.
  localparam logic [TO_W-1:0] ToLast = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_to_w;
  assign unused_to_w = ^TO_W;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    load_seed = 1'b0;
    shift_en  = 1'b0;
`ifdef GSA_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d   = StRun;
          load_seed = 1'b1;
          cnt_d     = '0;
          pass_d    = 1'b0;
`ifdef GSA_TIMEOUT_EN
          to_cnt_d  = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      StRun: begin
        if (bus.resp_valid) begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + 1'b1;
`ifdef GSA_TIMEOUT_EN
          to_cnt_d = '0;
`endif
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            pass_d  = (sig_next == bus.expected_sig);
          end
        end
`ifdef GSA_TIMEOUT_EN
        else if (to_cnt_q == ToLast) begin
          state_d   = StDone;
          to_cnt_d  = to_cnt_q + 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

`ifdef GSA_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.busy      = (state_q == StRun);
  assign bus.done      = (state_q == StDone);
  assign bus.pass      = pass_q;
  assign bus.signature = sig;
  assign bus.vec_count = cnt_q;

endmodule

// File: tb/tb_gate_sig_analyzer.sv
// Directed self-checking bench for gate_sig_analyzer with 4-sample sweeps.
module tb_gate_sig_analyzer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gate_sig_analyzer_if #(.IN_W(5), .SIG_W(16), .CNT_W(2)) bus_a ();
  gate_sig_analyzer_if #(.IN_W(5), .SIG_W(16), .CNT_W(2)) bus_b ();

  gate_sig_analyzer #(
    .IN_W (5),
    .SIG_W(16),
    .CNT_W(2),
    .POLY (16'h1021),
    .SEED (16'h0000),
    .TO_W (4)
  ) u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_a)
  );

  gate_sig_analyzer #(
    .IN_W (5),
    .SIG_W(16),
    .CNT_W(2),
    .POLY (16'h1021),
    .SEED (16'h8000),
    .TO_W (4)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a(input string tag, input logic b, input logic d, input logic p,
                         input logic [15:0] s, input logic [2:0] c, input logic t);
    chk({tag, ".busy"}, 32'(bus_a.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus_a.done), 32'(d));
    chk({tag, ".pass"}, 32'(bus_a.pass), 32'(p));
    chk({tag, ".sig"}, 32'(bus_a.signature), 32'(s));
    chk({tag, ".cnt"}, 32'(bus_a.vec_count), 32'(c));
    chk({tag, ".timeout"}, 32'(bus_a.timeout), 32'(t));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_a(input logic [4:0] r);
    bus_a.resp_valid = 1'b1;
    bus_a.resp       = r;
    step();
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.resp_valid = 1'b0; bus_a.resp = '0; bus_a.expected_sig = '0;
    bus_b.start = 1'b0; bus_b.resp_valid = 1'b0; bus_b.resp = '0; bus_b.expected_sig = '0;

    // Reset values
    step();
    step();
    check_a("reset", 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    chk("reset.b_sig", 32'(bus_b.signature), 32'h8000);
    rst_n = 1'b1;
    step();
    check_a("idle", 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);

    // Feedback-free shift; resp_valid alongside start must not be sampled
    bus_a.expected_sig = 16'h0008;
    bus_a.start = 1'b1; bus_a.resp_valid = 1'b1; bus_a.resp = 5'h05;
    step();
    bus_a.start = 1'b0;
    check_a("start", 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    sample_a(5'h01);
    check_a("shift1", 1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0);
    sample_a(5'h00);
    check_a("shift2", 1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 1'b0);
    sample_a(5'h00);
    check_a("shift3", 1'b1, 1'b0, 1'b0, 16'h0004, 3'd3, 1'b0);
    sample_a(5'h00);
    check_a("shift4_done", 1'b0, 1'b1, 1'b1, 16'h0008, 3'd4, 1'b0);
    sample_a(5'h1f);
    check_a("done_hold", 1'b0, 1'b1, 1'b1, 16'h0008, 3'd4, 1'b0);
    bus_a.resp_valid = 1'b0;

    // Mismatch: restart from DONE, same stimulus, wrong golden value
    bus_a.expected_sig = 16'h0009;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    check_a("restart", 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    sample_a(5'h01);
    sample_a(5'h00);
    sample_a(5'h00);
    sample_a(5'h00);
    bus_a.resp_valid = 1'b0;
    check_a("mismatch", 1'b0, 1'b1, 1'b0, 16'h0008, 3'd4, 1'b0);

    // Gaps plus start pulse inside RUN
    bus_a.expected_sig = 16'h0008;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    sample_a(5'h01);
    check_a("gap_s1", 1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0);
    bus_a.resp_valid = 1'b0;
    step();
    check_a("gap_idle1", 1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0);
    bus_a.start = 1'b1;
    sample_a(5'h00);
    bus_a.start = 1'b0;
    check_a("gap_start_ign", 1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 1'b0);
    bus_a.resp_valid = 1'b0;
    step();
    check_a("gap_idle2", 1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 1'b0);
    sample_a(5'h00);
    check_a("gap_s3", 1'b1, 1'b0, 1'b0, 16'h0004, 3'd3, 1'b0);
    sample_a(5'h00);
    bus_a.resp_valid = 1'b0;
    check_a("gap_done", 1'b0, 1'b1, 1'b1, 16'h0008, 3'd4, 1'b0);

    // Feedback tap on the SEED=0x8000 instance
    bus_b.expected_sig = 16'h811b;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    bus_b.resp_valid = 1'b1;
    bus_b.resp = 5'h00;
    step();
    chk("fb_s1", 32'(bus_b.signature), 32'h1021);
    bus_b.resp = 5'h03;
    step();
    chk("fb_s2", 32'(bus_b.signature), 32'h2041);
    bus_b.resp = 5'h00;
    step();
    chk("fb_s3", 32'(bus_b.signature), 32'h4082);
    bus_b.resp = 5'h1f;
    step();
    bus_b.resp_valid = 1'b0;
    chk("fb_sig", 32'(bus_b.signature), 32'h811b);
    chk("fb_done", 32'(bus_b.done), 32'h1);
    chk("fb_pass", 32'(bus_b.pass), 32'h1);

    // Asynchronous reset mid-sweep, then a fresh full sweep
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    sample_a(5'h01);
    sample_a(5'h00);
    bus_a.resp_valid = 1'b0;
    check_a("pre_rst", 1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_rst", 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    chk("async_rst.b_sig", 32'(bus_b.signature), 32'h8000);
    chk("async_rst.b_done", 32'(bus_b.done), 32'h0);
    #1;
    rst_n = 1'b1;
    step();
    bus_a.expected_sig = 16'h000b;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    sample_a(5'h01);
    sample_a(5'h00);
    sample_a(5'h01);
    sample_a(5'h01);
    bus_a.resp_valid = 1'b0;
    check_a("post_rst", 1'b0, 1'b1, 1'b1, 16'h000b, 3'd4, 1'b0);

`ifdef GSA_TIMEOUT_EN
    // Watchdog: one sample, then 15 idle cycles in RUN
    bus_a.expected_sig = 16'h0001;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    sample_a(5'h01);
    bus_a.resp_valid = 1'b0;
    repeat (14) step();
    check_a("wd_pre", 1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0);
    step();
    check_a("wd_fire", 1'b0, 1'b1, 1'b0, 16'h0001, 3'd1, 1'b1);
`else
    // Without the watchdog RUN waits indefinitely
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    sample_a(5'h01);
    bus_a.resp_valid = 1'b0;
    repeat (40) step();
    check_a("no_wd", 1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
